// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
//
// Packs decoded RV32I instruction descriptors into 32-bit instruction words.
// The encoded words are written to consecutive instruction-memory word
// addresses, starting at 0 for each load session. The block loads programs
// for the single-cycle core. It supports lw, sw, R-type, B-type, I-type ALU,
// jal and lui.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      open a session at word 0 (honoured in IDLE/DONE only)
//   in_valid   descriptor valid
//   in_ready   descriptor accepted when in_valid && in_ready
//   in_fmt     0=lw 1=sw 2=R 3=B 4=I-ALU 5=jal 6=lui 7=illegal
//   in_funct3  funct3 for R/B/I
//   in_f7b5    funct7[5] for R and I-shift
//   in_rd/in_rs1/in_rs2  register indices
//   in_imm     signed immediate (byte units for B/jal, pre-shifted for lui)
//   in_last    final descriptor of the session
//   mem_we     one-cycle write strobe
//   mem_addr   word address of the write
//   mem_wdata  encoded instruction
//   busy/done  session status
//   err        sticky illegal-format / overflow flag
//   count      words written this session
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | accepting descriptors, one per cycle
// DONE  | session ended (last beat or overflow), await start

module rv32i_instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] FMT_LW  = 3'd0;
    localparam logic [2:0] FMT_SW  = 3'd1;
    localparam logic [2:0] FMT_R   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_I   = 3'd4;
    localparam logic [2:0] FMT_JAL = 3'd5;
    localparam logic [2:0] FMT_LUI = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                accept;
    logic [31:0]         enc_word;
    logic [11:0]         i_imm;

    // Shift-immediate forms carry funct7 in the upper immediate bits.
    always_comb begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
            i_imm = {1'b0, in_f7b5, 5'b00000, in_imm[4:0]};
        end else begin
            i_imm = in_imm[11:0];
        end
    end

    always_comb begin
        enc_word = 32'h0;
        case (in_fmt)
            FMT_LW:  enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            FMT_SW:  enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                                 in_imm[4:0], 7'b0100011};
            FMT_R:   enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1,
                                 in_funct3, in_rd, 7'b0110011};
            FMT_B:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], 7'b1100011};
            FMT_I:   enc_word = {i_imm, in_rs1, in_funct3, in_rd, 7'b0010011};
            FMT_JAL: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, 7'b1101111};
            FMT_LUI: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            default: enc_word = 32'h0;
        endcase
    end

    assign accept = in_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (in_fmt == FMT_ILL) begin
                        // No write and no pointer advance; last still closes the session.
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = enc_word;
                        count_d     = count_q + CNT_ONE;
                        if (ptr_q == PTR_MAX) begin
                            // Memory full: the pointer stays put. More beats were expected unless last is set.
                            if (!in_last) begin
                                err_d = 1'b1;
                            end
                            state_d = ST_DONE;
                        end else begin
                            ptr_d = ptr_q + PTR_ONE;
                            if (in_last) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign count     = count_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed testbench for rv32i_instr_encoder with ADDR_W=2, so overflow
// happens at the fourth write. Inputs change 1 ns after the rising edge,
// and outputs are sampled at that same point.

module tb_rv32i_instr_encoder;

    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [2:0]    in_funct3;
    logic          in_f7b5;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    int tests_run;
    int tests_failed;

    rv32i_instr_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_funct3 (in_funct3),
        .in_f7b5   (in_f7b5),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [2:0] fmt, input logic [2:0] f3, input logic f7b5,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic last);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_funct3 = f3;
        in_f7b5   = f7b5;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [41:0] got;
        reset = 1'b0;
        tick();
        tick();
        got = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count};
        tests_run++;
        if (got !== 42'h0) begin
            tests_failed++;
            $display("FAIL reset_values got=%h exp=0", got);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({busy, done, in_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_after_reset got=%b exp=000", {busy, done, in_ready});
        end
    endtask

    task automatic test_itype();
        open_session();
        tests_run++;
        if ({busy, in_ready, count, err} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_entry got busy=%b rdy=%b cnt=%0d err=%b", busy, in_ready, count, err);
        end
        set_desc(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd0, 32'h00500093}) begin
            tests_failed++;
            $display("FAIL itype_write got we=%b a=%0d d=%h exp 1/0/00500093", mem_we, mem_addr, mem_wdata);
        end
        tests_run++;
        if ({done, busy, in_ready, count} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
            tests_failed++;
            $display("FAIL itype_done got done=%b busy=%b rdy=%b cnt=%0d", done, busy, in_ready, count);
        end
        tick();
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 2'd0, 32'h00500093}) begin
            tests_failed++;
            $display("FAIL itype_hold got we=%b a=%0d d=%h exp 0/0/00500093", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_back_to_back();
        open_session();
        set_desc(3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        tick();
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd0, 32'h002081B3}) begin
            tests_failed++;
            $display("FAIL add_write got we=%b a=%0d d=%h exp 1/0/002081B3", mem_we, mem_addr, mem_wdata);
        end
        set_desc(3'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd1, 32'h402081B3}) begin
            tests_failed++;
            $display("FAIL sub_write got we=%b a=%0d d=%h exp 1/1/402081B3", mem_we, mem_addr, mem_wdata);
        end
        tests_run++;
        if ({done, count} !== {1'b1, 3'd2}) begin
            tests_failed++;
            $display("FAIL b2b_done got done=%b cnt=%0d exp 1/2", done, count);
        end
    endtask

    task automatic test_formats();
        logic [2:0]  fmts [6];
        logic [2:0]  f3s  [6];
        logic [4:0]  rds  [6];
        logic [4:0]  rs1s [6];
        logic [4:0]  rs2s [6];
        logic [31:0] imms [6];
        logic [31:0] exps [6];
        fmts = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd6, 3'd4};
        f3s  = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101};
        rds  = '{5'd5, 5'd0, 5'd0, 5'd1, 5'd5, 5'd4};
        rs1s = '{5'd2, 5'd2, 5'd1, 5'd0, 5'd0, 5'd3};
        rs2s = '{5'd0, 5'd5, 5'd2, 5'd0, 5'd0, 5'd0};
        imms = '{32'd8, 32'd12, 32'hFFFF_FFFC, 32'd8, 32'h1234_5000, 32'h0000_0FE3};
        // lw x5,8(x2); sw x5,12(x2); beq x1,x2,-4; jal x1,8; lui x5,0x12345; srai x4,x3,3
        exps = '{32'h00812283, 32'h00512623, 32'hFE208EE3, 32'h008000EF,
                 32'h123452B7, 32'h4031D213};
        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 0) open_session();
            set_desc(fmts[i], f3s[i], (i == 5), rds[i], rs1s[i], rs2s[i], imms[i], (i % 3 == 2));
            tick();
            in_valid = 1'b0;
            tests_run++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'(i % 3), exps[i]}) begin
                tests_failed++;
                $display("FAIL fmt_vec%0d got we=%b a=%0d d=%h exp 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i % 3, exps[i]);
            end
        end
        tests_run++;
        if ({done, count, err} !== {1'b1, 3'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL fmt_done got done=%b cnt=%0d err=%b", done, count, err);
        end
    endtask

    task automatic test_overflow();
        open_session();
        set_desc(3'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 1'b0);
        tick();
        set_desc(3'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        tick();
        tests_run++;
        if ({mem_we, err, count, busy} !== {1'b0, 1'b1, 3'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL illegal_beat got we=%b err=%b cnt=%0d busy=%b exp 0/1/1/1", mem_we, err, count, busy);
        end
        for (int i = 1; i < 4; i++) begin
            set_desc(3'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_1000 * (i + 1), 1'b0);
            tick();
            tests_run++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'(i), 32'h000000B7 | (32'h1000 * (i + 1))}) begin
                tests_failed++;
                $display("FAIL ovf_write%0d got we=%b a=%0d d=%h", i, mem_we, mem_addr, mem_wdata);
            end
        end
        tests_run++;
        if ({done, busy, err, count, in_ready} !== {1'b1, 1'b0, 1'b1, 3'd4, 1'b0}) begin
            tests_failed++;
            $display("FAIL overflow_done got done=%b busy=%b err=%b cnt=%0d rdy=%b exp 1/0/1/4/0",
                     done, busy, err, count, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({mem_we, count, done} !== {1'b0, 3'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL overflow_stop got we=%b cnt=%0d done=%b", mem_we, count, done);
        end
        open_session();
        tests_run++;
        if ({err, count, busy} !== {1'b0, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL restart_clear got err=%b cnt=%0d busy=%b exp 0/0/1", err, count, busy);
        end
        set_desc(3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        tick();
        tests_run++;
        if ({mem_we, mem_addr} !== {1'b1, 2'd0}) begin
            tests_failed++;
            $display("FAIL restart_addr got we=%b a=%0d exp 1/0", mem_we, mem_addr);
        end
        set_desc(3'd7, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({mem_we, done, err, count} !== {1'b0, 1'b1, 1'b1, 3'd1}) begin
            tests_failed++;
            $display("FAIL illegal_last got we=%b done=%b err=%b cnt=%0d exp 0/1/1/1", mem_we, done, err, count);
        end
    endtask

    task automatic test_midreset();
        logic [41:0] got;
        open_session();
        set_desc(3'd4, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
        tick();
        set_desc(3'd4, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'd9, 1'b0);
        reset = 1'b0;
        tick();
        got = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count};
        tests_run++;
        if (got !== 42'h0) begin
            tests_failed++;
            $display("FAIL midreset_values got=%h exp=0", got);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({mem_we, busy, count} !== {1'b0, 1'b0, 3'd0}) begin
                tests_failed++;
                $display("FAIL midreset_quiet%0d got we=%b busy=%b cnt=%0d", i, mem_we, busy, count);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 3'd0;
        in_funct3 = 3'd0;
        in_f7b5   = 1'b0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_imm    = 32'd0;
        in_last   = 1'b0;
        test_reset();
        test_itype();
        test_back_to_back();
        test_formats();
        test_overflow();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
